// File: rtl/wb_regfile.sv
// Write-back select, 32x32 architectural register file with same-cycle bypass,
// and a per-register pending scoreboard that stalls decode on in-flight producers.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        MentoRegtoRe,
  input  logic        RegWrtoRe,
  input  logic        jartoRe,
  input  logic        JtoRe,
  input  logic [4:0]  rwtoRe,
  input  logic [31:0] pcNewtoRe,
  input  logic [31:0] ALUout,
  input  logic [31:0] MenouttoRe,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] busA,
  output logic [31:0] busB,
  input  logic        issue_we,
  input  logic [4:0]  issue_rw,
  output logic        stall,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [5:0]  pend_cnt
);

  logic [31:0] regs [1:31];
  logic [31:1] pending_r;
  logic [31:0] pending;
  logic [31:1] pending_next;
  logic [5:0]  cnt_next;
  logic        hit_a;
  logic        hit_b;

  // Link writes to r31 override the normal destination and the jump suppression.
  always_comb begin
    wb_dest = rwtoRe;
    wb_data = MentoRegtoRe ? MenouttoRe : ALUout;
    wb_we   = RegWrtoRe & ~JtoRe & (rwtoRe != 5'd0);
    if (jartoRe) begin
      wb_dest = 5'd31;
      wb_data = pcNewtoRe;
      wb_we   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_we) begin
      regs[wb_dest] <= wb_data;
    end
  end

  always_comb begin
    busA = 32'd0;
    busB = 32'd0;
    if (ra != 5'd0) busA = (wb_we && wb_dest == ra) ? wb_data : regs[ra];
    if (rb != 5'd0) busB = (wb_we && wb_dest == rb) ? wb_data : regs[rb];
  end

  assign pending = {pending_r, 1'b0};

  // Clear first, then set, so a newly issued producer supersedes the retiring one.
  always_comb begin
    pending_next = pending_r;
    if (wb_we) pending_next[wb_dest] = 1'b0;
    if (issue_we && issue_rw != 5'd0) pending_next[issue_rw] = 1'b1;
    cnt_next = 6'd0;
    for (int i = 1; i < 32; i++) cnt_next = cnt_next + 6'(pending_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= '0;
      pend_cnt  <= 6'd0;
    end else begin
      pending_r <= pending_next;
      pend_cnt  <= cnt_next;
    end
  end

  assign hit_a = pending[ra] & ~(wb_we & (wb_dest == ra));
  assign hit_b = pending[rb] & ~(wb_we & (wb_dest == rb));
  assign stall = hit_a | hit_b;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the pipelined CPU. It consumes the MEM/WB pipeline register outputs, which update on the falling clock edge. It selects the write-back value, commits it to a 32×32 register file on the rising edge, and serves the two decode-stage read ports with same-cycle write bypass. A per-register pending scoreboard raises `stall` when decode reads a register that still has an in-flight producer.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register index.

Ports:
- `clk`  in  1  pipeline clock; file and scoreboard update on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `MentoRegtoRe`  in  1  1: write back memory data; 0: write back ALU result
- `RegWrtoRe`  in  1  register write request from MEM/WB
- `jartoRe`  in  1  link write: `pcNewtoRe` to r31
- `JtoRe`  in  1  jump marker; with `jartoRe`=0 it suppresses the write
- `rwtoRe`  in  5  destination register
- `pcNewtoRe`  in  32  link address
- `ALUout`  in  32  ALU result
- `MenouttoRe`  in  32  memory read data
- `ra`, `rb`  in  5 each  decode read addresses
- `busA`, `busB`  out  32 each  read data, combinational
- `issue_we`  in  1  decode issues an instruction that will write `issue_rw`
- `issue_rw`  in  5  destination of the issued instruction
- `stall`  out  1  decode must hold
- `wb_we`  out  1  effective write enable this cycle
- `wb_dest`  out  5  effective destination
- `wb_data`  out  32  effective write data
- `pend_cnt`  out  6  number of pending registers, 0..31

## Operation
- Destination:
  - `jartoRe`=1: `wb_dest`=31, `wb_data`=`pcNewtoRe`, `wb_we`=1, regardless of `RegWrtoRe`/`rwtoRe`.
  - Otherwise: `wb_dest`=`rwtoRe`; `wb_data`=`MenouttoRe` if `MentoRegtoRe`=1, else `ALUout`.
  - `wb_we`=`RegWrtoRe` & ~`JtoRe` & (`wb_dest`≠0).
- r0: reads always return 0; writes to r0 are dropped. `wb_we`=0 whenever `wb_dest`=0.
- Write: on rising `clk`, if `wb_we`, then regs[`wb_dest`] ← `wb_data`.
- Reads: `busA` = 0 if `ra`=0; else `wb_data` if `wb_we` and `wb_dest`=`ra`; else regs[`ra`]. `busB` works the same way with `rb`.
- Scoreboard: `pending[31:1]`, bit 0 is constant 0. On rising `clk`:
  - clear `pending[wb_dest]` if `wb_we`;
  - then set `pending[issue_rw]` if `issue_we` and `issue_rw`≠0.
  - If set and clear target the same register in the same cycle, the set wins, because the new producer supersedes the old one.
- stall:
  - `hitA` = `pending[ra]` & ~(`wb_we` & `wb_dest`=`ra`); `hitB` is the same with `rb`.
  - `stall` = `hitA` | `hitB`.
  - A register being written this cycle is bypassed, not stalled.
- `pend_cnt`: registered popcount of `pending`, updated in the same edge as `pending`.

## Timing
- Reset (async, immediate on `rst`=1): all 32 registers, `pending` and `pend_cnt` go to 0. `busA`/`busB` then read 0 and `stall`=0.
- The `wb_*` outputs are combinational from the inputs and remain valid during reset.
- Reset released mid-sequence: the next rising edge behaves as the first edge; no write is replayed.
- Write latency:
  - value visible on `busA`/`busB` in the same cycle through the bypass;
  - in the array from the next rising edge.
- MEM/WB inputs change on the falling edge, so they are stable for the second half-cycle before the rising-edge commit.
- Scoreboard latency:
  - a set from `issue_we` at edge N raises `stall` for matching reads from edge N onward;
  - the clearing write at edge M drops `stall` combinationally in the cycle before M, through the bypass term.
- `issue_we` for r0 has no effect and `stall` for r0 reads is never asserted.
- `pend_cnt` saturates naturally at 31, since r0 is excluded.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle after writing r5=0x1234 → `busA`(ra=5)=0 immediately, `pend_cnt`=0, `stall`=0.
- ALU vs memory select: `RegWrtoRe`=1, `rwtoRe`=7, `ALUout`=0xAAAA0001, `MenouttoRe`=0x5555_0002, `MentoRegtoRe`=0 → r7=0xAAAA0001. Repeat with `MentoRegtoRe`=1 → r7=0x55550002.
- Link and jump: `jartoRe`=1, `pcNewtoRe`=0x00400010, `rwtoRe`=3, `RegWrtoRe`=0 → r31=0x00400010, r3 unchanged. `JtoRe`=1 with `jartoRe`=0, `RegWrtoRe`=1 → no write, `wb_we`=0.
- r0 and bypass:
  - write 0xFFFFFFFF to r0 → `busA`(ra=0)=0;
  - with `rwtoRe`=9 writing 0x77 and ra=9 in the same cycle → `busA`=0x77 before the edge.
- Scoreboard:
  - `issue_we`=1, `issue_rw`=4 at edge N → `stall`=1 for rb=4, `pend_cnt`=1;
  - write-back of r4 → `stall`=0 in that cycle, `pend_cnt`=0 after the edge.
- Simultaneous set and clear on r4 at the same edge → `pending[4]` stays 1, `pend_cnt` unchanged, `stall` remains 1 on the following cycle.
